// File: rtl/apb_master_pkg.sv
// Shared state encoding and helpers for the APB4 master mux.
package apb_master_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_SETUP  = 2'd1;
    localparam logic [1:0] ENC_ACCESS = 2'd2;
    localparam logic [1:0] ENC_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SETUP  = ENC_SETUP,
        ST_ACCESS = ENC_ACCESS,
        ST_RESP   = ENC_RESP
    } apb_state_t;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Index-based return path select: picks one slave's PRDATA/PREADY/PSLVERR.
module apb_rsp_mux
    import apb_master_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [IDX_W-1:0]          idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata_all,
    input  logic [NUM_SLV-1:0]        pready_all,
    input  logic [NUM_SLV-1:0]        pslverr_all,
    output logic [DATA_W-1:0]         prdata,
    output logic                      pready,
    output logic                      pslverr
);

    always_comb begin
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                prdata  = prdata_all[i*DATA_W +: DATA_W];
                pready  = pready_all[i];
                pslverr = pslverr_all[i];
            end
        end
    end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master: valid/ready command in, one-hot PSEL bus out, valid/ready response back.
// Optional access timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_mux
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLV        = 4,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_wdata,
    input  logic [strb_w(DATA_W)-1:0]   cmd_strb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [NUM_SLV-1:0]          PSEL,
    output logic                        PENABLE,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    output logic [strb_w(DATA_W)-1:0]   PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]          PREADY,
    input  logic [NUM_SLV-1:0]          PSLVERR
);

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // SETUP  | PSEL asserted, PENABLE low, one cycle
    // ACCESS | PENABLE high, waiting for selected PREADY
    // RESP   | rsp_valid high until rsp_ready

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [SEL_W:0] NUM_SLV_EXT = (SEL_W+1)'(NUM_SLV);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (NUM_SLV < 1 || NUM_SLV > (1 << SEL_W)) begin : g_bad_num_slv
        $error("NUM_SLV must be in 1..2**SEL_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_t         state;
    logic [IDX_W-1:0]   sel_idx;
    logic [SEL_W-1:0]   cmd_idx;
    logic [DATA_W-1:0]  sel_prdata;
    logic               sel_pready;
    logic               sel_pslverr;
    logic               timeout_hit;

    assign cmd_idx   = cmd_addr[ADDR_W-1 -: SEL_W];
    assign cmd_ready = (state == ST_IDLE) && !rsp_valid;

    apb_rsp_mux #(
        .NUM_SLV (NUM_SLV),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_rsp_mux (
        .idx         (sel_idx),
        .prdata_all  (PRDATA),
        .pready_all  (PREADY),
        .pslverr_all (PSLVERR),
        .prdata      (sel_prdata),
        .pready      (sel_pready),
        .pslverr     (sel_pslverr)
    );

`ifdef APB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !sel_pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The miss that would bring the count to TIMEOUT_CYCLES aborts; a ready in that cycle still wins.
    assign timeout_hit = (state == ST_ACCESS) && !sel_pready && (wait_cnt == WAIT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            sel_idx   <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if ({1'b0, cmd_idx} < NUM_SLV_EXT) begin
                            state   <= ST_SETUP;
                            sel_idx <= cmd_idx[IDX_W-1:0];
                            PSEL    <= NUM_SLV'(1) << cmd_idx;
                            PENABLE <= 1'b0;
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_wdata;
                            PSTRB   <= cmd_write ? cmd_strb : '0;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (sel_pready) begin
                        state     <= ST_RESP;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_pslverr;
                        rsp_rdata <= (!PWRITE && !sel_pslverr) ? sel_prdata : '0;
                    end else if (timeout_hit) begin
                        state     <= ST_RESP;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_mux.sv
// Self-checking bench for apb_master_mux: directed plan cases plus randomized transactions.
module tb_apb_master_mux;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int NUM_SLV        = 4;
    localparam int SEL_W          = 3;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int STRB_W         = DATA_W / 8;

    logic                      PCLK = 1'b0;
    logic                      PRESETn = 1'b0;
    logic                      cmd_valid = 1'b0;
    logic                      cmd_ready;
    logic                      cmd_write = 1'b0;
    logic [ADDR_W-1:0]         cmd_addr = '0;
    logic [DATA_W-1:0]         cmd_wdata = '0;
    logic [STRB_W-1:0]         cmd_strb = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic [STRB_W-1:0]         PSTRB;
    logic [NUM_SLV*DATA_W-1:0] PRDATA = '0;
    logic [NUM_SLV-1:0]        PREADY = '0;
    logic [NUM_SLV-1:0]        PSLVERR = '0;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W-1:0] last_paddr = '0;

    always #5 PCLK = ~PCLK;

    apb_master_mux #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
        .SEL_W(SEL_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Non-selected slaves get random noise every cycle so the return mux is exercised.
    task automatic drive_slaves(input int sel, input bit rdy, input logic [DATA_W-1:0] rd, input bit err);
        for (int i = 0; i < NUM_SLV; i++) begin
            PRDATA[i*DATA_W +: DATA_W] = $urandom;
            PREADY[i]  = 1'($urandom_range(0, 1));
            PSLVERR[i] = 1'($urandom_range(0, 1));
        end
        if (sel >= 0 && sel < NUM_SLV) begin
            PRDATA[sel*DATA_W +: DATA_W] = rd;
            PREADY[sel]  = rdy;
            PSLVERR[sel] = err;
        end
    endtask

    task automatic do_reset();
        #2 PRESETn = 1'b0;
        #7 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        last_paddr = '0;
    endtask

    // One command end to end; waits = PREADY-low cycles of the selected slave.
    task automatic run_txn(input string name, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                           input int waits, input logic [DATA_W-1:0] rdata, input bit slverr,
                           input int rsp_hold);
        int idx, lat, access_cycles;
        bit dec_err, to_abort, exp_err, in_setup, in_access;
        logic [DATA_W-1:0] exp_rdata;
        logic [NUM_SLV-1:0] exp_psel;
        logic [STRB_W-1:0] exp_strb;

        idx      = int'(addr[ADDR_W-1 -: SEL_W]);
        dec_err  = idx >= NUM_SLV;
        to_abort = 1'b0;
`ifdef APB_TIMEOUT_EN
        to_abort = !dec_err && waits >= TIMEOUT_CYCLES;
`endif
        access_cycles = to_abort ? TIMEOUT_CYCLES : waits + 1;
        lat       = dec_err ? 1 : 2 + access_cycles;
        exp_err   = dec_err || to_abort || slverr;
        exp_rdata = (!wr && !exp_err) ? rdata : '0;
        exp_strb  = wr ? strb : '0;

        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s.cmd_ready_idle got=%b want=1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        drive_slaves(-1, 1'b0, '0, 1'b0);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
        cmd_strb = STRB_W'($urandom);

        for (int n = 1; n <= lat; n++) begin
            in_setup  = !dec_err && n == 1;
            in_access = !dec_err && n >= 2 && n < lat;
            exp_psel  = (in_setup || in_access) ? (NUM_SLV'(1) << idx) : '0;
            checks++;
            if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== {exp_psel, in_access, (n == lat), 1'b0}) begin
                failures++;
                $display("FAIL %s.ctl cyc=%0d got psel=%b pen=%b rv=%b crdy=%b want psel=%b pen=%b rv=%b crdy=0",
                         name, n, PSEL, PENABLE, rsp_valid, cmd_ready, exp_psel, in_access, (n == lat));
            end
            if (in_setup || in_access) begin
                checks++;
                if ({PADDR, PWRITE, PWDATA, PSTRB} !== {addr, wr, wdata, exp_strb}) begin
                    failures++;
                    $display("FAIL %s.bus cyc=%0d got a=%h w=%b d=%h s=%b want a=%h w=%b d=%h s=%b",
                             name, n, PADDR, PWRITE, PWDATA, PSTRB, addr, wr, wdata, exp_strb);
                end
            end
            if (dec_err) begin
                checks++;
                if (PADDR !== last_paddr) begin
                    failures++;
                    $display("FAIL %s.paddr_hold got=%h want=%h", name, PADDR, last_paddr);
                end
            end
            if (in_access)
                drive_slaves(idx, (n - 2) >= waits, rdata, slverr);
            else
                drive_slaves(-1, 1'b0, '0, 1'b0);
            if (n < lat) begin
                rsp_ready = 1'($urandom_range(0, 1));
                @(posedge PCLK); #1;
            end
        end

        for (int k = 0; k < 40 && rsp_valid !== 1'b1; k++) begin
            @(posedge PCLK); #1;
        end
        if (rsp_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s.rsp_timeout got rsp_valid=%b want=1", name, rsp_valid);
            do_reset();
            return;
        end

        for (int h = 0; h <= rsp_hold; h++) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready, PSEL} !== {1'b1, exp_err, exp_rdata, 1'b0, {NUM_SLV{1'b0}}}) begin
                failures++;
                $display("FAIL %s.rsp hold=%0d got v=%b e=%b d=%h crdy=%b psel=%b want v=1 e=%b d=%h crdy=0 psel=0",
                         name, h, rsp_valid, rsp_err, rsp_rdata, cmd_ready, PSEL, exp_err, exp_rdata);
            end
            rsp_ready = (h == rsp_hold);
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s.rsp_done got v=%b crdy=%b want v=0 crdy=1", name, rsp_valid, cmd_ready);
        end
        if (!dec_err) last_paddr = addr;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            failures++;
            $display("FAIL reset.outputs got psel=%b pen=%b a=%h w=%b d=%h s=%b rv=%b rd=%h re=%b want all 0",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset.cmd_ready got=%b want=1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        run_txn("wr_idx0", 1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'b0101, 0, 32'h0, 1'b0, 0);
        run_txn("rd_idx2_wait3", 1'b0, 32'h4000_0000, 32'h0, 4'b1111, 3, 32'h1234_5678, 1'b0, 0);
        run_txn("rd_decerr", 1'b0, 32'hA000_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 0);
        run_txn("wr_slverr_hold", 1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'b1111, 0, 32'h0, 1'b1, 5);
        run_txn("rd_slverr", 1'b0, 32'h6000_0004, 32'h0, 4'b0000, 1, 32'h5555_AAAA, 1'b1, 1);
        run_txn("wr_decerr_top", 1'b1, 32'hE000_0000, 32'h1111_2222, 4'b1111, 0, 32'h0, 1'b0, 2);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        for (int t = 0; t < 30; t++) begin
            a = $urandom;
            run_txn("rand", 1'($urandom_range(0, 1)), a, $urandom, STRB_W'($urandom),
                    $urandom_range(0, 4), $urandom, ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_access();
        bit bad;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h2000_0100; cmd_wdata = 32'h0BAD_0BAD;
        cmd_strb = 4'hF;
        PREADY = '0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #3;
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== '0) begin
            failures++;
            $display("FAIL rst_access.async got psel=%b pen=%b rv=%b want 0", PSEL, PENABLE, rsp_valid);
        end
        #3 PRESETn = 1'b1;
        last_paddr = '0;
        PREADY = '1; rsp_ready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge PCLK); #1;
            if (rsp_valid !== 1'b0 || PSEL !== '0 || cmd_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rst_access.no_rsp got rv=%b psel=%b crdy=%b want rv=0 psel=0 crdy=1",
                     rsp_valid, PSEL, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        run_txn("wait15", 1'b0, 32'h6000_0000, 32'h0, 4'h0, 15, 32'hA5A5_5A5A, 1'b0, 0);
        run_txn("wait20", 1'b0, 32'h2000_0000, 32'h0, 4'h0, 20, 32'h0F0F_F0F0, 1'b0, 0);
        run_txn("wait_stuck", 1'b1, 32'h0000_0008, 32'h7777_8888, 4'h3, 1000, 32'h0, 1'b0, 0);
`ifndef APB_TIMEOUT_EN
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h6000_0000;
        drive_slaves(-1, 1'b0, '0, 1'b0);
        PREADY = '0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k < 100; k++) begin
            @(posedge PCLK); #1;
        end
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== {4'b1000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL stuck_access got psel=%b pen=%b rv=%b want psel=1000 pen=1 rv=0",
                     PSEL, PENABLE, rsp_valid);
        end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_in_access();
        test_timeout();
        run_txn("post_timeout_wr", 1'b1, 32'h0000_0000, 32'h1357_9BDF, 4'b1001, 2, 32'h0, 1'b0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
Parametrised APB4 master bridging a simple valid/ready command port onto an APB bus shared by NUM_SLV slaves.
- Decodes the slave index from the top SEL_W address bits and drives a one-hot PSEL.
- Muxes per-slave PRDATA/PREADY/PSLVERR back to the master.
- Returns read data and error status on a valid/ready response port.
- Replaces the fixed 2-slave, 32-bit master; adds wait-state handling, strobes, decode error and back-pressure.

Parameters:
- ADDR_W, 32: PADDR width; the slave index is bits [ADDR_W-1 -: SEL_W].
- DATA_W, 32: data width; must be a multiple of 8.
- NUM_SLV, 4: number of slaves; must satisfy 1 <= NUM_SLV <= 2**SEL_W.
- SEL_W, 3: number of address bits used for slave decode.
- TIMEOUT_CYCLES, 16: access wait-state limit; only used with APB_TIMEOUT_EN.

Ports:
- PCLK, in, 1: clock.
- PRESETn, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid and cmd_ready are both high at a rising edge.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_W: target address.
- cmd_wdata, in, DATA_W: write data.
- cmd_strb, in, DATA_W/8: write byte strobes.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: response consumed.
- rsp_rdata, out, DATA_W: read data; 0 for writes and errors.
- rsp_err, out, 1: slave error, decode error or timeout.
- PSEL, out, NUM_SLV: one-hot slave select.
- PENABLE, out, 1: APB enable.
- PADDR, out, ADDR_W: APB address.
- PWRITE, out, 1: APB write.
- PWDATA, out, DATA_W: APB write data.
- PSTRB, out, DATA_W/8: APB strobes.
- PRDATA, in, NUM_SLV*DATA_W: per-slave read data, packed; slave i at [i*DATA_W +: DATA_W].
- PREADY, in, NUM_SLV: per-slave ready.
- PSLVERR, in, NUM_SLV: per-slave error.

Behaviour:
- Reset (async, PRESETn low): state IDLE; PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata and rsp_err all 0. A transfer in flight is dropped and produces no response.
- cmd_ready = (state==IDLE) && !rsp_valid, so it is 1 in the first cycle after reset release.
- FSM states: IDLE, SETUP, ACCESS, RESP. All bus outputs are registered.
- IDLE, command accepted:
  - Latch addr, write, wdata and strb; compute idx = addr[ADDR_W-1 -: SEL_W].
  - idx < NUM_SLV: go to SETUP with PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the command.
  - PSTRB = cmd_strb for writes; PSTRB = 0 for reads (APB4 rule).
  - idx >= NUM_SLV (decode error): no bus activity; go to RESP with rsp_err=1 and rsp_rdata=0.
- SETUP: unconditionally go to ACCESS next cycle with PENABLE=1. PSEL, PADDR, PWRITE, PWDATA and PSTRB stay stable.
- ACCESS:
  - Sample PREADY[idx] each cycle.
  - While it is 0, stay in ACCESS with all bus signals held.
  - On 1, capture rsp_err = PSLVERR[idx] and rsp_rdata = (read && !PSLVERR[idx]) ? PRDATA[idx] : 0.
  - Then clear PSEL/PENABLE and go to RESP.
  - PREADY and PSLVERR of non-selected slaves are ignored.
- RESP: rsp_valid=1. On rsp_ready, clear rsp_valid and go to IDLE. If rsp_ready stays 0, the response is held indefinitely with rsp_rdata/rsp_err stable.
- Latency (PREADY=1 on first access cycle, rsp_ready=1):
  - Accept at edge T; SETUP in T+1; ACCESS in T+2; rsp_valid in T+3; cmd_ready again in T+4.
  - Every wait state adds one cycle.
  - Decode error: rsp_valid in T+1.
- PADDR, PWDATA and PSTRB keep their last value when idle. PWRITE keeps its last value when idle.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When it reaches TIMEOUT_CYCLES, abort: PSEL/PENABLE go to 0 on the next edge, rsp_err=1, rsp_rdata=0, go to RESP.
  - PREADY arriving in the same cycle the count hits the limit completes normally, i.e. the ready wins.
- Not defined: no counter is instantiated; ACCESS waits forever.

Decomposition:
- Package apb_master_pkg: state enum type, state encoding localparams (IDLE, SETUP, ACCESS, RESP) and the strobe-width function.
- One sub-module, apb_rsp_mux: combinational index-based select of PRDATA/PREADY/PSLVERR, parametrised by NUM_SLV and DATA_W.

Test Plan:
- Write, addr 0x1000_0040 (idx 0), wdata 0xDEADBEEF, strb 4'b0101, PREADY[0]=1 immediately:
  - PSEL=4'b0001 at T+1 with PENABLE=0, PENABLE=1 at T+2, PSTRB=0101.
  - rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read, idx 2 (addr 0x4000_0000), slave 2 holds PREADY low 3 cycles, PRDATA=0x12345678:
  - ACCESS lasts 4 cycles, PSTRB=0.
  - rsp_rdata=0x12345678 at T+6.
- Read to idx 5 (addr 0xA000_0000) with NUM_SLV=4:
  - PSEL stays 0 throughout.
  - rsp_valid at T+1 with rsp_err=1.
- Write with PSLVERR[1]=1 and PREADY[1]=1, rsp_ready held 0 for 5 cycles:
  - rsp_err=1 held stable; cmd_ready=0 until rsp_ready rises.
- PRESETn pulsed low during ACCESS: PSEL, PENABLE and rsp_valid are 0 immediately (asynchronously); no response appears after release.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck at 0:
  - Abort after 16 ACCESS cycles with rsp_err=1.
  - Without the macro, the bus is still in ACCESS at cycle 100.
